// File: rtl/calc_pkg.sv
// Shared types and sizing helpers for the calculator datapath blocks.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Iteration-counter width for an n-bit divider. It never goes below 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DIV_N     = 4;
  localparam int DIV_CNT_W = cnt_w(DIV_N);

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, then trial-subtract the divisor.
module div_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r_i,
  input  logic         d_bit_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] r_o,
  output logic         q_bit_o
);

  logic [N:0] r_shift;
  logic [N:0] trial;

  // Before each shift the partial remainder is below 2^(N-1).
  // r_shift therefore always fits in N bits, and trial[N] is a true borrow.
  assign r_shift = {r_i, d_bit_i};
  assign trial   = r_shift - {1'b0, b_i};

  assign q_bit_o = ~trial[N];
  assign r_o     = q_bit_o ? trial[N-1:0] : r_shift[N-1:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider that produces one quotient bit per clock.
// Results stay visible until the next operation completes.
module seq_divider
  import calc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder_mod,
  output logic         error_div,
  output logic         error_mod
);

  localparam int CW = cnt_w(N);

  div_state_t     state_q, state_d;
  logic [N-1:0]   d_q, d_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   r_q, r_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   quo_q, quo_d;
  logic [N-1:0]   rem_q, rem_d;
  logic           err_q, err_d;

  logic [N-1:0]   r_next;
  logic           q_bit;

  div_step #(.N(N)) u_step (
    .r_i     (r_q),
    .d_bit_i (d_q[N-1]),
    .b_i     (b_q),
    .r_o     (r_next),
    .q_bit_o (q_bit)
  );

  // NOTE: sequential state is written with non-blocking assignments only.
  // All registers in the block then sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    // NOTE: the default assignment at the top keeps this block purely combinational.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (b != '0) ? CALC : DONE;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CALC);
    done = (state_q == DONE);
  end

  // Datapath next-state logic. The result registers load only on the edge that enters DONE.
  always_comb begin
    d_d   = d_q;
    b_d   = b_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    rem_d = rem_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (b != '0) begin
            d_d   = a;
            b_d   = b;
            r_d   = '0;
            cnt_d = CW'(N - 1);
          end else begin
            quo_d = '0;
            rem_d = '0;
            err_d = 1'b1;
          end
        end
      end
      CALC: begin
        d_d   = {d_q[N-2:0], q_bit};
        r_d   = r_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          quo_d = {d_q[N-2:0], q_bit};
          rem_d = r_next;
          err_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      d_q   <= d_d;
      b_q   <= b_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      err_q <= err_d;
    end
  end

  assign quotient      = quo_q;
  assign remainder_mod = rem_q;
  assign error_div     = err_q;
  assign error_mod     = err_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of seq_divider against a scoreboard of model results.
module tb_seq_divider;

  localparam int N = 4;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         err;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder_mod;
  logic         error_div;
  logic         error_mod;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t hold;

  seq_divider #(.N(N)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .a             (a),
    .b             (b),
    .busy          (busy),
    .done          (done),
    .quotient      (quotient),
    .remainder_mod (remainder_mod),
    .error_div     (error_div),
    .error_mod     (error_mod)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Move to the next cycle. Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv);
    exp_t e;
    if (bv == '0) begin
      e.q = '0; e.r = '0; e.err = 1'b1;
    end else begin
      e.q = av / bv; e.r = av % bv; e.err = 1'b0;
    end
    return e;
  endfunction

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_q"},   quotient,      e.q);
    check({tag, "_r"},   remainder_mod, e.r);
    check({tag, "_ed"},  error_div,     e.err);
    check({tag, "_em"},  error_mod,     e.err);
    hold = e;
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_hold_q"}, quotient,      hold.q);
    check({tag, "_hold_r"}, remainder_mod, hold.r);
    check({tag, "_hold_e"}, error_div,     hold.err);
  endtask

  // Issue one operation and wait for done with a bounded wait. Check latency, busy and holding.
  task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv);
    int cyc;
    bit seen;
    sb.push_back(model(av, bv));
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        check({tag, "_busy"}, busy, 32'(bv != '0));
        check_hold(tag);
        tick();
      end
    end
    check({tag, "_latency"}, cyc, (bv == '0) ? 1 : N + 1);
    check({tag, "_busy_at_done"}, busy, 0);
    compare_out(tag);
    tick();
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin : stim
    int  done_cnt;
    bit  seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    hold = '{q: '0, r: '0, err: 1'b0};
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check_hold("rst");
    check("rst_em", error_mod, 0);
    rst = 1'b0;
    tick();

    run_op("div13_3", 4'd13, 4'd3);
    run_op("div7_0",  4'd7,  4'd0);
    run_op("div6_2",  4'd6,  4'd2);
    run_op("div15_1", 4'd15, 4'd1);
    run_op("div3_5",  4'd3,  4'd5);
    run_op("div0_9",  4'd0,  4'd9);

    // A second start during CALC, with changed operands, must be ignored.
    sb.push_back(model(4'd12, 4'd4));
    a = 4'd12; b = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    done_cnt = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 2) begin
        a = 4'd9; b = 4'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        done_cnt++;
        check("ign_latency", cyc, N + 1);
        compare_out("ign");
      end
      tick();
    end
    start = 1'b0;
    check("ign_done_count", done_cnt, 1);
    check("ign_sb_drained", sb.size(), 0);

    // A synchronous reset mid-CALC aborts the operation without a done pulse.
    a = 4'd14; b = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold = '{q: '0, r: '0, err: 1'b0};
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check_hold("abort");
    seen = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (done === 1'b1) seen = 1'b1;
      tick();
    end
    check("abort_no_done", seen, 0);
    run_op("div14_3", 4'd14, 4'd3);

    for (int ai = 0; ai < 16; ai++)
      for (int bi = 0; bi < 16; bi++)
        run_op("sweep", 4'(ai), 4'(bi));

    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
